pit_timer: RTL and testbench
============================

Name: pit_timer

Overview:
- Wishbone slave implementing a reduced 8254 programmable interval timer: channel 0 only, modes 2 and 3, binary counting.
- Sits on the io window 0x40–0x43 (slave 7 of the system switch).
- Responds to CPU I/O cycles and drives the level output that feeds interrupt vector bit 0 (system tick, 18.2 Hz with the BIOS default count).

Parameters:
- PRESCALE, 10: wb_clk_i cycles per timer count; 12.5 MHz / 10 approximates the 1.19 MHz PIT input.
- PW, 4: prescaler counter width; must satisfy 2^PW ≥ PRESCALE.

Ports:
- wb_clk_i  in  1  system clock
- wb_rst_i  in  1  reset, synchronous, active-low
- wb_adr_i  in  1  address bit 1: 0 selects io 0x40/0x41, 1 selects io 0x42/0x43
- wb_sel_i  in  2  byte lanes; [0] is the even port, [1] is the odd port
- wb_dat_i  in  16  write data
- wb_dat_o  out  16  read data
- wb_we_i  in  1  write enable
- wb_stb_i  in  1  strobe
- wb_cyc_i  in  1  cycle
- wb_ack_o  out  1  acknowledge
- tick  out  1  channel 0 OUT level

Behaviour:
- Reset (wb_rst_i=0 sampled on an edge) forces:
  - wb_ack_o=0, wb_dat_o=0, tick=1
  - prescaler=0, count=0, reload=0, counting disabled
  - mode=2, rw=11 (LSB then MSB)
  - write/read byte flip-flops=LSB, latch invalid
  - Reset mid-transaction drops ack; the cycle is not completed.
- Handshake:
  - wb_ack_o <= wb_stb_i & wb_cyc_i & ~wb_ack_o. One-cycle latency; a held strobe gives ack on alternating cycles.
  - wb_dat_o is registered in the same cycle as ack. Register side effects happen only on the cycle ack is set.
- Port map:
  - 0x40 = ch0 data.
  - 0x41 and 0x42 are unimplemented: read 0x00, writes ignored.
  - 0x43 = control: write-only, reads 0x00.
  - sel=11 on 0x40/0x41 processes 0x40 only; the upper byte reads 0x00.
- Control word (0x43):
  - SC[7:6]≠00: ignored.
  - RW[5:4]=00 (latch command): copies the live count into the latch, unless the latch is already valid (then ignored).
  - RW≠00: stores rw and mode, resets both byte flip-flops, invalidates the latch, disables counting, sets tick=1.
  - Mode field: M[3:1] x10 → mode 2, x11 → mode 3, anything else → mode 2.
  - BCD bit [0] is ignored.
- Count write (0x40):
  - rw=01: reload={8'h00,d}.
  - rw=10: reload={d,8'h00}.
  - rw=11: first write sets the low byte (counting stays disabled); second write sets the high byte.
  - On the completing write: load_pending=1, counting enabled, prescaler cleared.
- Count read (0x40):
  - Source is the latch if valid, else the live count.
  - rw=01 returns the low byte; rw=10 returns the high byte.
  - rw=11 alternates low/high via the read flip-flop.
  - The latch is invalidated after its final byte is read.
- Prescaler:
  - Counts 0..PRESCALE-1 while counting is enabled.
  - en pulses for one cycle when it wraps.
- Effective N = reload, with 0 → 65536 and 1 → 2. Count register is 17 bits internally; reads return bits [15:0].
- On en with load_pending: count=N, load_pending=0, tick=1, mode-3 phase=high.
- Mode 2 on en:
  - count==1 → count=N, tick=1.
  - Otherwise count-=1, with tick=0 when the new count is 1.
  - Result: tick is low for exactly 1 of every N en periods.
- Mode 3 on en:
  - count-=1.
  - When count reaches 1: toggle phase and reload. The high phase reloads ceil(N/2); the low phase reloads floor(N/2).
  - tick=phase.
  - Result: period N, high for ceil(N/2), low for floor(N/2).
- Simultaneous events:
  - A count write on the same cycle as en: the write wins; that en is dropped.
  - A control write on the same cycle as en: counting halts and tick=1.

Test Plan:
- Reset, then read 0x40 (sel=01) → ack exactly 1 cycle after stb; dat_o=0x0000; tick=1.
- PRESCALE=2: ctrl 0x34 (mode 2, LSB/MSB), write 0x40 = 0x05 then 0x00 → tick low for 2 clocks every 10 clocks.
- PRESCALE=2: ctrl 0x36 (mode 3), count 5 → tick high for 6 clocks, low for 4, repeating.
- Count 0x1234 running, ctrl 0x00 (latch), read 0x40 twice → latched low then high byte; later reads return the live count.
- Ctrl 0x16 (LSB only), write 0x40 = 0x03, sel=11 data 0xFF03 → reload 0x0003; the 0x41 byte is ignored; mode 3 period 3 (high 2 en periods, low 1).
- Running mode 2, then wb_rst_i=0 for 1 cycle during a held stb → no ack that cycle; tick=1; counter halted until a new count is written.

Source files
------------

// File: rtl/pit_timer.sv
// pit_timer: Wishbone slave implementing a reduced 8254 interval timer.
// Only channel 0 exists. It supports modes 2 and 3 with binary counting.
// The slave decodes io 0x40-0x43:
//   0x40 = ch0 data, 0x43 = control word (write-only).
//   0x41 and 0x42 read as zero and ignore writes.
// Ports:
//   wb_clk_i  system clock
//   wb_rst_i  synchronous active-low reset
//   wb_adr_i  0 selects 0x40/0x41, 1 selects 0x42/0x43
//   wb_sel_i  byte lanes; [0] is the even port, [1] is the odd port
//   wb_dat_i  write data
//   wb_dat_o  registered read data
//   wb_we_i, wb_stb_i, wb_cyc_i  Wishbone cycle qualifiers
//   wb_ack_o  one-cycle acknowledge
//   tick      channel 0 OUT level (system tick interrupt source)
module pit_timer #(
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned PW       = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wb_adr_i,
  input  logic [1:0]  wb_sel_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        tick
);

  typedef enum logic {MODE2, MODE3} mode_t;

  logic [PW-1:0] prescaler;
  logic          counting;
  logic          load_pending;
  logic          phase;
  logic          wr_ff;
  logic          rd_ff;
  logic          latch_valid;
  logic [16:0]   count;
  logic [15:0]   reload;
  logic [15:0]   latch;
  logic [1:0]    rw;
  mode_t         mode;

  logic          ack_set;
  logic          data_wr;
  logic          data_rd;
  logic          ctrl_sel;
  logic          ctrl_wr;
  logic          latch_cmd;
  logic          data_done;
  logic          en;
  logic          rd_hi;
  logic          rd_last;
  logic [15:0]   rd_src;
  logic [7:0]    rd_byte;
  logic [7:0]    wr_byte;
  logic [16:0]   n_eff;
  logic [16:0]   half_hi;
  logic [16:0]   half_lo;
  logic [16:0]   count_dec;
  logic          unused_ctrl;

  assign ack_set   = wb_stb_i & wb_cyc_i & ~wb_ack_o;
  assign data_wr   = ack_set & wb_we_i & ~wb_adr_i & wb_sel_i[0];
  assign data_rd   = ack_set & ~wb_we_i & ~wb_adr_i & wb_sel_i[0];
  // Control byte sits on the odd lane of 0x42/0x43; SC other than 0 is ignored.
  assign ctrl_sel  = ack_set & wb_we_i & wb_adr_i & wb_sel_i[1] & (wb_dat_i[15:14] == 2'b00);
  assign latch_cmd = ctrl_sel & (wb_dat_i[13:12] == 2'b00);
  assign ctrl_wr   = ctrl_sel & (wb_dat_i[13:12] != 2'b00);
  // M[2] and BCD have no effect in this reduced timer.
  assign unused_ctrl = ^{wb_dat_i[11], wb_dat_i[8]};

  assign wr_byte   = wb_dat_i[7:0];
  assign data_done = data_wr & ((rw != 2'b11) | wr_ff);
  assign en        = counting & (prescaler == PW'(PRESCALE - 1));

  assign rd_src  = latch_valid ? latch : count[15:0];
  assign rd_hi   = (rw == 2'b10) | ((rw == 2'b11) & rd_ff);
  assign rd_byte = rd_hi ? rd_src[15:8] : rd_src[7:0];
  assign rd_last = (rw != 2'b11) | rd_ff;

  assign count_dec = count - 17'd1;

  always_comb begin
    n_eff = {1'b0, reload};
    if (reload == 16'h0000) n_eff = 17'h10000;
    else if (reload == 16'h0001) n_eff = 17'd2;
    half_hi = (n_eff + 17'd1) >> 1;
    half_lo = n_eff >> 1;
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      wb_ack_o     <= 1'b0;
      wb_dat_o     <= '0;
      tick         <= 1'b1;
      prescaler    <= '0;
      count        <= '0;
      reload       <= '0;
      counting     <= 1'b0;
      load_pending <= 1'b0;
      phase        <= 1'b1;
      mode         <= MODE2;
      rw           <= 2'b11;
      wr_ff        <= 1'b0;
      rd_ff        <= 1'b0;
      latch        <= '0;
      latch_valid  <= 1'b0;
    end else begin
      wb_ack_o <= ack_set;
      if (ack_set) wb_dat_o <= data_rd ? {8'h00, rd_byte} : '0;

      if (counting)
        prescaler <= (prescaler == PW'(PRESCALE - 1)) ? '0 : prescaler + PW'(1);

      if (data_rd) begin
        if (rw == 2'b11) rd_ff <= ~rd_ff;
        if (rd_last) latch_valid <= 1'b0;
      end

      if (latch_cmd && !latch_valid) begin
        latch       <= count[15:0];
        latch_valid <= 1'b1;
      end

      // Control and count writes take priority over a coincident en, which is lost.
      if (ctrl_wr) begin
        rw          <= wb_dat_i[13:12];
        mode        <= (wb_dat_i[10:9] == 2'b11) ? MODE3 : MODE2;
        wr_ff       <= 1'b0;
        rd_ff       <= 1'b0;
        latch_valid <= 1'b0;
        counting    <= 1'b0;
        tick        <= 1'b1;
      end else if (data_wr) begin
        case (rw)
          2'b01:   reload <= {8'h00, wr_byte};
          2'b10:   reload <= {wr_byte, 8'h00};
          default: begin
            if (wr_ff) reload[15:8] <= wr_byte;
            else       reload[7:0]  <= wr_byte;
            wr_ff <= ~wr_ff;
          end
        endcase
        if (data_done) begin
          load_pending <= 1'b1;
          counting     <= 1'b1;
          prescaler    <= '0;
        end
      end else if (en) begin
        if (load_pending) begin
          count        <= n_eff;
          load_pending <= 1'b0;
          tick         <= 1'b1;
          phase        <= 1'b1;
        end else if (mode == MODE2) begin
          if (count == 17'd1) begin
            count <= n_eff;
            tick  <= 1'b1;
          end else begin
            count <= count_dec;
            tick  <= (count_dec != 17'd1);
          end
        end else begin
          // Entering the high phase reloads ceil(N/2), the low phase floor(N/2).
          if (count == 17'd1) begin
            phase <= ~phase;
            tick  <= ~phase;
            count <= phase ? half_lo : half_hi;
          end else begin
            count <= count_dec;
            tick  <= phase;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pit_timer.sv
module tb_pit_timer;

  localparam int K_NONE    = 0;
  localparam int K_FIXED   = 1;
  localparam int K_LIVE_LO = 2;
  localparam int K_LIVE_HI = 3;
  localparam int K_UPPER0  = 4;

  typedef struct {
    logic        adr;
    logic [1:0]  sel;
    logic        we;
    logic [15:0] dat;
    int          kind;
    logic [15:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] exp;
    logic [15:0] mask;
  } sb_t;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b0;
  logic        wb_adr_i = 1'b0;
  logic [1:0]  wb_sel_i = '0;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic        wb_we_i  = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_ack_o;
  logic        tick;

  int unsigned cycle = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  sb_t         sb_q[$];
  vec_t        tab[$];
  int unsigned p0 = 0;
  logic [16:0] n_eff = '0;

  pit_timer #(.PRESCALE(2), .PW(2)) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_i(wb_rst_i),
    .wb_adr_i(wb_adr_i),
    .wb_sel_i(wb_sel_i),
    .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o),
    .wb_we_i (wb_we_i),
    .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o),
    .tick    (tick)
  );

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cycle <= cycle + 32'd1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Count value just after posedge e, for a mode-2 count loaded at p0 that has not wrapped.
  // The load happens on the second edge after the completing write, then one decrement per 2 edges.
  function automatic logic [15:0] live(input int unsigned e);
    logic [16:0] c;
    c = n_eff - 17'((e - p0 - 32'd2) / 32'd2);
    return c[15:0];
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic bus(input logic adr, input logic [1:0] sel, input logic we,
                     input logic [15:0] dat, input int kind, input logic [15:0] exp,
                     input string name, output int unsigned ack_edge);
    int unsigned lat;
    logic [15:0] lv;
    sb_t s;
    @(negedge wb_clk_i);
    wb_adr_i = adr; wb_sel_i = sel; wb_we_i = we; wb_dat_i = dat;
    wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    if (!we && kind != K_NONE) begin
      s.name = name;
      s.mask = 16'hFFFF;
      lv = live(cycle);
      case (kind)
        K_LIVE_LO: s.exp = {8'h00, lv[7:0]};
        K_LIVE_HI: s.exp = {8'h00, lv[15:8]};
        K_UPPER0:  begin s.exp = 16'h0000; s.mask = 16'hFF00; end
        default:   s.exp = exp;
      endcase
      sb_q.push_back(s);
    end
    lat = 0;
    do begin
      @(negedge wb_clk_i);
      lat++;
    end while (!wb_ack_o && lat < 8);
    ack_edge = cycle;
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0; wb_we_i = 1'b0;
    check({name, "_ack_latency"}, lat, 32'd1);
    if (!we && kind != K_NONE && sb_q.size() > 0) begin
      s = sb_q.pop_front();
      check(s.name, 32'(wb_dat_o & s.mask), 32'(s.exp & s.mask));
    end
  endtask

  function automatic void add(input logic adr, input logic [1:0] sel, input logic we,
                              input logic [15:0] dat, input int kind, input logic [15:0] exp,
                              input string name);
    vec_t v;
    v.adr = adr; v.sel = sel; v.we = we; v.dat = dat;
    v.kind = kind; v.exp = exp; v.name = name;
    tab.push_back(v);
  endfunction

  task automatic run_tab();
    int unsigned e;
    for (int i = 0; i < tab.size(); i++)
      bus(tab[i].adr, tab[i].sel, tab[i].we, tab[i].dat, tab[i].kind, tab[i].exp, tab[i].name, e);
    tab.delete();
  endtask

  task automatic measure(output int lo, output int hi);
    int t;
    lo = 0; hi = 0; t = 0;
    while (tick !== 1'b1 && t < 300) begin @(negedge wb_clk_i); t++; end
    t = 0;
    while (tick === 1'b1 && t < 300) begin @(negedge wb_clk_i); t++; end
    while (tick === 1'b0 && lo < 300) begin @(negedge wb_clk_i); lo++; end
    while (tick === 1'b1 && hi < 300) begin @(negedge wb_clk_i); hi++; end
  endtask

  task automatic expect_period(input string name, input int exp_lo, input int exp_hi);
    int lo, hi;
    measure(lo, hi);
    check({name, "_low_clocks"}, 32'(lo), 32'(exp_lo));
    check({name, "_high_clocks"}, 32'(hi), 32'(exp_hi));
  endtask

  task automatic count_lows(input int n, output int lows);
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge wb_clk_i);
      if (tick !== 1'b1) lows++;
    end
  endtask

  task automatic load16(input logic [15:0] v);
    int unsigned e;
    bus(1'b0, 2'b01, 1'b1, {8'h00, v[7:0]}, K_NONE, '0, "wr_lsb", e);
    bus(1'b0, 2'b01, 1'b1, {8'h00, v[15:8]}, K_NONE, '0, "wr_msb", p0);
    n_eff = (v == 16'h0000) ? 17'h10000 : (v == 16'h0001) ? 17'd2 : {1'b0, v};
  endtask

  task automatic ctrl(input logic [7:0] c);
    int unsigned e;
    bus(1'b1, 2'b10, 1'b1, {c, 8'h00}, K_NONE, '0, "ctrl", e);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lows;
    int unsigned e, pl;
    logic [15:0] latched;

    // Reset state
    idle(3);
    check("reset_ack", 32'(wb_ack_o), 32'd0);
    check("reset_dat", 32'(wb_dat_o), 32'd0);
    check("reset_tick", 32'(tick), 32'd1);
    wb_rst_i = 1'b1;

    // Port map after reset
    add(1'b0, 2'b01, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd40_lo_reset");
    add(1'b0, 2'b01, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd40_hi_reset");
    add(1'b0, 2'b10, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd41_zero");
    add(1'b1, 2'b01, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd42_zero");
    add(1'b1, 2'b10, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd43_zero");
    add(1'b0, 2'b10, 1'b1, 16'h1200, K_NONE,  16'h0000, "wr41");
    add(1'b1, 2'b01, 1'b1, 16'h0034, K_NONE,  16'h0000, "wr42");
    add(1'b0, 2'b11, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd40_sel11");
    run_tab();
    check("tick_idle", 32'(tick), 32'd1);

    // Held strobe acks on alternating cycles
    @(negedge wb_clk_i);
    wb_adr_i = 1'b1; wb_sel_i = 2'b01; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge wb_clk_i);
      check("held_stb_ack", 32'(wb_ack_o), 32'((i % 2) == 0));
    end
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;

    // Mode 2, N=5: first byte alone must not start counting
    ctrl(8'h34);
    bus(1'b0, 2'b01, 1'b1, 16'h0005, K_NONE, '0, "wr_lsb_only", e);
    count_lows(20, lows);
    check("no_start_after_lsb", 32'(lows), 32'd0);
    bus(1'b0, 2'b01, 1'b1, 16'h0000, K_NONE, '0, "wr_msb", p0);
    expect_period("m2_n5_a", 2, 8);
    expect_period("m2_n5_b", 2, 8);

    // Ignored writes: SC=01 control, 0x41 and 0x42 data
    add(1'b1, 2'b10, 1'b1, 16'h7600, K_NONE, 16'h0000, "ctrl_sc01");
    add(1'b0, 2'b10, 1'b1, 16'h9900, K_NONE, 16'h0000, "wr41_run");
    add(1'b1, 2'b01, 1'b1, 16'h0099, K_NONE, 16'h0000, "wr42_run");
    run_tab();
    expect_period("m2_after_ignored", 2, 8);

    // Reset during a held strobe
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_NONE, '0, "rd_prefill", e);
    @(negedge wb_clk_i);
    wb_adr_i = 1'b0; wb_sel_i = 2'b01; wb_we_i = 1'b0; wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);
    check("rst_mid_no_ack", 32'(wb_ack_o), 32'd0);
    check("rst_mid_tick", 32'(tick), 32'd1);
    check("rst_mid_dat", 32'(wb_dat_o), 32'd0);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    check("post_rst_ack", 32'(wb_ack_o), 32'd1);
    check("post_rst_dat", 32'(wb_dat_o), 32'd0);
    wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    count_lows(40, lows);
    check("halted_after_rst", 32'(lows), 32'd0);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_FIXED, 16'h0000, "rd_hi_after_rst", e);
    load16(16'h0005);
    expect_period("m2_after_rst", 2, 8);

    // Mode 3, N=5
    ctrl(8'h36);
    load16(16'h0005);
    expect_period("m3_n5_a", 4, 6);
    expect_period("m3_n5_b", 4, 6);

    // LSB-only access, odd lane ignored, mode 3 N=3
    add(1'b1, 2'b10, 1'b1, 16'h1600, K_NONE,   16'h0000, "ctrl_16");
    add(1'b0, 2'b01, 1'b1, 16'h0003, K_NONE,   16'h0000, "wr_lsb3");
    add(1'b0, 2'b11, 1'b1, 16'hFF03, K_NONE,   16'h0000, "wr_sel11");
    add(1'b0, 2'b11, 1'b0, 16'h0000, K_UPPER0, 16'h0000, "rd_sel11_upper");
    run_tab();
    expect_period("m3_n3", 2, 4);

    // Reload 1 acts as 2
    ctrl(8'h14);
    bus(1'b0, 2'b01, 1'b1, 16'h0001, K_NONE, '0, "wr_one", e);
    expect_period("m2_n1_as_2", 2, 2);

    // Latch command on a running 0x1234 count
    ctrl(8'h34);
    load16(16'h1234);
    idle(6);
    bus(1'b1, 2'b10, 1'b1, 16'h0000, K_NONE, '0, "latch_cmd", pl);
    latched = live(pl - 32'd1);
    idle(10);
    ctrl(8'h00);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_FIXED, {8'h00, latched[7:0]},  "latch_lo", e);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_FIXED, {8'h00, latched[15:8]}, "latch_hi", e);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_LIVE_LO, '0, "live_lo", e);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_LIVE_HI, '0, "live_hi", e);

    // Reload 0 acts as 65536
    ctrl(8'h34);
    load16(16'h0000);
    idle(3);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_LIVE_LO, '0, "n0_live_lo", e);
    bus(1'b0, 2'b01, 1'b0, 16'h0000, K_LIVE_HI, '0, "n0_live_hi", e);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
